// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pixel streamer: FSM encoding and border pad value.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_t;

  localparam int PAD_VALUE = 0;

endpackage

// File: rtl/sobel_stream_fifo.sv
// 2-entry pixel FIFO with occupancy count; simultaneous push and pop allowed.
// Latency: written data visible at head the cycle after push.
// Backpressure: caller must not push when full nor pop when empty.
module sobel_stream_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/sobel_pixel_streamer.sv
// Streams one frame from frame memory in raster order; SOBEL_STREAMER_PAD_EN adds a zero border.
// Latency: first pixel 2 cycles after start_i, then one per cycle while ready_i is high.
// Backpressure: at most 2 pixels in flight/buffered; data_o/we_o hold while ready_i is low.
module sobel_pixel_streamer
  import sobel_pkg::*;
#(
  parameter int ROWS       = 5,
  parameter int COLS       = 6,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  ready_i,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  we_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  done_o
);

`ifdef SOBEL_STREAMER_PAD_EN
  localparam int OUT_ROWS = ROWS + 2;
  localparam int OUT_COLS = COLS + 2;
`else
  localparam int OUT_ROWS = ROWS;
  localparam int OUT_COLS = COLS;
`endif
  localparam int RW = $clog2(OUT_ROWS + 1);
  localparam int CW = $clog2(OUT_COLS + 1);

  stream_state_t         state_q, state_d;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         col_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  infl_q;
  logic                  infl_pad_q;
  logic                  done_q;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [1:0]            fifo_count;
  logic [1:0]            occ;
  logic                  border;
  logic                  issue;
  logic                  last_col;
  logic                  last_slot;
  logic                  out_vld;
  logic                  xfer;
  logic                  last_xfer;
  logic [DATA_WIDTH-1:0] infl_dat;

  assign last_col  = (col_q == CW'(OUT_COLS - 1));
  assign last_slot = last_col && (row_q == RW'(OUT_ROWS - 1));

`ifdef SOBEL_STREAMER_PAD_EN
  assign border = (row_q == '0) || (row_q == RW'(OUT_ROWS - 1)) ||
                  (col_q == '0) || last_col;
`else
  assign border = 1'b0;
`endif

  // A slot is a memory read or an injected border pixel; both take one cycle to land.
  assign occ       = fifo_count + {1'b0, infl_q};
  assign issue     = (state_q == ST_READ) && (occ < 2'd2);
  assign out_vld   = infl_q || (fifo_count != 2'd0);
  assign xfer      = out_vld && ready_i;
  assign last_xfer = (state_q == ST_DRAIN) && xfer && (occ == 2'd1);
  assign infl_dat  = infl_pad_q ? DATA_WIDTH'(PAD_VALUE) : mem_data_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i && !done_q) state_d = ST_READ;
      ST_READ:  if (issue && last_slot) state_d = ST_DRAIN;
      ST_DRAIN: if (last_xfer)          state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      infl_q     <= 1'b0;
      infl_pad_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      infl_q     <= issue;
      infl_pad_q <= issue && border;
      done_q     <= last_xfer;
      if (issue) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_slot ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
        if (last_slot) begin
          addr_q <= '0;
        end else if (!border) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Landing pixel bypasses the FIFO when it is empty and downstream takes it.
  sobel_stream_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q && !(ready_i && (fifo_count == 2'd0))),
    .push_data (infl_dat),
    .pop       (ready_i && (fifo_count != 2'd0)),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign mem_rd_o   = issue && !border;
  assign mem_addr_o = mem_rd_o ? addr_q : '0;
  assign we_o       = out_vld;
  assign data_o     = (fifo_count != 2'd0) ? fifo_head :
                      infl_q               ? infl_dat  : '0;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;

endmodule

// File: tb/tb_sobel_pixel_streamer.sv
// Scoreboard bench for sobel_pixel_streamer (ROWS=5, COLS=6, mem[a]=a+1).
module tb_sobel_pixel_streamer;

  localparam int ROWS = 5;
  localparam int COLS = 6;
  localparam int DW   = 8;
  localparam int AW   = 5;
`ifdef SOBEL_STREAMER_PAD_EN
  localparam int N_OR = ROWS + 2;
  localparam int N_OC = COLS + 2;
`else
  localparam int N_OR = ROWS;
  localparam int N_OC = COLS;
`endif
  localparam int N_PIX = N_OR * N_OC;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic          ready_i;
  logic          mem_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i;
  logic          we_o;
  logic [DW-1:0] data_o;
  logic          busy_o;
  logic          done_o;

  sobel_pixel_streamer #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ready_i(ready_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .we_o(we_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memory: one-cycle read latency, garbage when not read.
  always @(posedge clk)
    mem_data_i <= mem_rd_o ? DW'(mem_addr_o + 1) : DW'($urandom);

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int cyc = 0;
  int t0, rel;
  bit mon_en = 0;
  int xfer_cnt, rd_cnt, done_cnt, done_rel, first_we, last_we;
  int busy_cnt, busy_first, busy_last, max_out, addr_idle_bad, dat5;
  bit stall_prev;
  int stall_dat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_pix(input int idx);
    int r, c;
    r = idx / N_OC;
    c = idx % N_OC;
`ifdef SOBEL_STREAMER_PAD_EN
    if (r == 0 || r == N_OR - 1 || c == 0 || c == N_OC - 1) return 0;
    return (r - 1) * COLS + (c - 1) + 1;
`else
    return r * COLS + c + 1;
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - t0;
      if (busy_o) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      if (we_o) begin
        if (first_we < 0) first_we = rel;
        last_we = rel;
      end
      if (rel == 5) dat5 = int'(data_o);
      if (done_o) begin
        done_cnt++;
        done_rel = rel;
      end
      if (mem_rd_o) begin
        check("rd_addr", mem_addr_o, rd_cnt);
        rd_cnt++;
      end else if (mem_addr_o != '0) begin
        addr_idle_bad++;
      end
      if (rd_cnt - xfer_cnt > max_out) max_out = rd_cnt - xfer_cnt;
      if (stall_prev) begin
        check("hold_vld", we_o, 1);
        check("hold_dat", data_o, stall_dat);
      end
      stall_prev = we_o && !ready_i;
      stall_dat  = int'(data_o);
      if (we_o && ready_i) begin
        if (exp_q.size() == 0) check("xfer_overrun", xfer_cnt + 1, N_PIX);
        else check("pixel", data_o, exp_q.pop_front());
        xfer_cnt++;
      end
    end
  end

  task automatic reset_stats();
    exp_q.delete();
    xfer_cnt = 0; rd_cnt = 0; done_cnt = 0; done_rel = -1;
    first_we = -1; last_we = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    max_out = 0; addr_idle_bad = 0; dat5 = -1; stall_prev = 0; stall_dat = 0;
    for (int i = 0; i < N_PIX; i++) exp_q.push_back(exp_pix(i));
  endtask

  function automatic bit ready_for(input int mode, input int k);
    case (mode)
      1:       return !(k >= 5 && k <= 8);
      2:       return (k % 2) == 0;
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready high, 1: stall cycles 5-8, 2: ready toggling, 3: repeated start_i
  task automatic run_frame(input int mode);
    int seen;
    reset_stats();
    @(posedge clk); #1;
    t0 = cyc; start_i = 1'b1; ready_i = ready_for(mode, 0); mon_en = 1'b1;
    seen = -1;
    for (int k = 1; k < 400; k++) begin
      @(posedge clk); #1;
      start_i = (mode == 3) && (k == 5 || k == 20 || k == N_PIX + 2);
      ready_i = ready_for(mode, k);
      if (done_cnt > 0 && seen < 0) seen = k;
      if (seen >= 0 && k >= seen + 4) break;
    end
    start_i = 1'b0; ready_i = 1'b1; mon_en = 1'b0;
    check("done_seen", done_cnt, 1);
    check("xfer_count", xfer_cnt, N_PIX);
    check("queue_left", exp_q.size(), 0);
    check("rd_count", rd_cnt, ROWS * COLS);
    check("addr_idle", addr_idle_bad, 0);
    check("outstanding_le2", max_out <= 2, 1);
    check("busy_end", busy_o, 0);
    if (mode == 0 || mode == 3) begin
      check("first_we", first_we, 2);
      check("last_we", last_we, N_PIX + 1);
      check("done_cycle", done_rel, N_PIX + 2);
      check("busy_first", busy_first, 1);
      check("busy_last", busy_last, N_PIX + 1);
      check("busy_cycles", busy_cnt, N_PIX + 1);
    end
    if (mode == 1) begin
      check("stall_dat", dat5, exp_pix(3));
      check("stall_done", done_rel, N_PIX + 6);
    end
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", we_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rd", mem_rd_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);

    // Reset mid-frame at pixel 10, then a clean restart.
    reset_stats();
    @(posedge clk); #1;
    t0 = cyc; start_i = 1'b1; mon_en = 1'b1;
    for (int k = 1; k < 100 && xfer_cnt < 9; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    check("rst_at_pix", xfer_cnt, 9);
    check("pix10", data_o, exp_pix(9));
    rst = 1'b0;
    #1;
    mon_en = 1'b0;
    check("mid_rst_we", we_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_rd", mem_rd_o, 0);
    check("mid_rst_addr", mem_addr_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
